// File: rtl/tw_pkg.sv
// Shared types, widths and constants for the twiddle buffer/sequencer.
// Default geometry matches the radix-16 NTT datapath.
package tw_pkg;

  function automatic int tw_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TW_LANES   = 2;
  localparam int TW_DW      = 64;
  localparam int TW_STAGES  = 3;
  localparam int TW_GROUPS  = 4;
  localparam int TW_ENTRIES = 4;
  localparam int TW_REPEAT  = 16;
  localparam int TW_WW      = TW_LANES * TW_DW;
  localparam int TW_SW      = tw_clog2(TW_STAGES);
  localparam int TW_GW      = tw_clog2(TW_GROUPS);
  localparam int TW_EW      = tw_clog2(TW_ENTRIES);
  localparam int TW_RW      = tw_clog2(TW_REPEAT);

  typedef logic [TW_WW-1:0] tw_word_t;

  // Identity word: every lane holds the field element 1.
  localparam tw_word_t TW_ID = {TW_LANES{TW_DW'(1)}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tw_state_e;

endpackage

// File: rtl/tw_seq_ctr.sv
// Nested entry -> repeat -> group counters for the twiddle read sequencer.
// o_last flags the final word of a run while its counters are presented.
module tw_seq_ctr
  import tw_pkg::*;
#(
  parameter int GROUPS  = TW_GROUPS,
  parameter int ENTRIES = TW_ENTRIES,
  parameter int REPEAT  = TW_REPEAT,
  localparam int GW = tw_clog2(GROUPS),
  localparam int EW = tw_clog2(ENTRIES),
  localparam int RW = tw_clog2(REPEAT)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_adv,
  input  logic [GW-1:0] i_last_grp,
  output logic [EW-1:0] o_ent,
  output logic [RW-1:0] o_rep,
  output logic [GW-1:0] o_grp,
  output logic          o_last
);

  logic [EW-1:0] r_ent;
  logic [RW-1:0] r_rep;
  logic [GW-1:0] r_grp;
  logic          w_ent_wrap;
  logic          w_rep_wrap;
  logic          w_grp_last;

  assign w_ent_wrap = (r_ent == EW'(ENTRIES - 1));
  assign w_rep_wrap = (r_rep == RW'(REPEAT - 1));
  assign w_grp_last = (r_grp == i_last_grp);

  // Counter chain: entry wraps into repeat, repeat wraps into group.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ent <= '0;
      r_rep <= '0;
      r_grp <= '0;
    end else if (i_clr) begin
      r_ent <= '0;
      r_rep <= '0;
      r_grp <= '0;
    end else if (i_adv) begin
      r_ent <= w_ent_wrap ? '0 : r_ent + 1'b1;
      if (w_ent_wrap) begin
        r_rep <= w_rep_wrap ? '0 : r_rep + 1'b1;
        if (w_rep_wrap) begin
          r_grp <= w_grp_last ? '0 : r_grp + 1'b1;
        end
      end
    end
  end

  assign o_ent  = r_ent;
  assign o_rep  = r_rep;
  assign o_grp  = r_grp;
  assign o_last = w_ent_wrap & w_rep_wrap & w_grp_last;

endmodule

// File: rtl/tw_buf_seq.sv
// Runtime-loadable twiddle table with a built-in read sequencer: streams one
// word per enabled cycle plus the per-stage constant of the running stage.
module tw_buf_seq
  import tw_pkg::*;
#(
  parameter int LANES   = TW_LANES,
  parameter int DW      = TW_DW,
  parameter int STAGES  = TW_STAGES,
  parameter int GROUPS  = TW_GROUPS,
  parameter int ENTRIES = TW_ENTRIES,
  parameter int REPEAT  = TW_REPEAT,
  localparam int WW = LANES * DW,
  localparam int SW = tw_clog2(STAGES),
  localparam int GW = tw_clog2(GROUPS),
  localparam int EW = tw_clog2(ENTRIES),
  localparam int RW = tw_clog2(REPEAT)
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SW-1:0]    stage_sel,
  input  logic [GW:0]      num_groups,
  input  logic             CEN,
  input  logic             wr_en,
  input  logic [SW-1:0]    wr_stage,
  input  logic [GW-1:0]    wr_group,
  input  logic [EW-1:0]    wr_entry,
  input  logic [LANES-1:0] wr_lane_mask,
  input  logic [WW-1:0]    wr_data,
  input  logic             const_we,
  output logic [WW-1:0]    Q,
  output logic             Q_valid,
  output logic [WW-1:0]    Q_const,
  output logic             busy,
  output logic             done
);

  localparam logic [WW-1:0] ID = {LANES{DW'(1)}};

  logic [WW-1:0] r_tbl   [STAGES][GROUPS][ENTRIES];
  logic [WW-1:0] r_const [STAGES];

  tw_state_e     r_state;
  tw_state_e     w_next_state;
  logic [SW-1:0] r_stage;
  logic [GW-1:0] r_last_grp;

  logic          w_accept;
  logic          w_adv;
  logic          w_last;
  logic [EW-1:0] w_ent;
  logic [RW-1:0] w_rep;
  logic [GW-1:0] w_grp;
  logic [GW-1:0] w_ng_last;
  logic [SW-1:0] w_stage_sel;
  logic          w_wr_ok;
  logic          w_cw_ok;
  logic          w_fwd_hit;
  logic [WW-1:0] w_wmask;
  logic [WW-1:0] w_wr_merged;
  logic [WW-1:0] w_rd_raw;
  logic [WW-1:0] w_rd_word;

  tw_seq_ctr #(
    .GROUPS  (GROUPS),
    .ENTRIES (ENTRIES),
    .REPEAT  (REPEAT)
  ) u_ctr (
    .i_clk      (CLK),
    .i_rst_n    (rst_n),
    .i_clr      (w_accept),
    .i_adv      (w_adv),
    .i_last_grp (r_last_grp),
    .o_ent      (w_ent),
    .o_rep      (w_rep),
    .o_grp      (w_grp),
    .o_last     (w_last)
  );

  // Run-parameter clamping: a zero or oversized group count walks every group.
  always_comb begin
    w_ng_last   = GW'(GROUPS - 1);
    w_stage_sel = SW'(STAGES - 1);
    if ((num_groups == '0) || (int'(num_groups) > GROUPS)) begin
      w_ng_last = GW'(GROUPS - 1);
    end else begin
      w_ng_last = GW'(num_groups - 1'b1);
    end
    if (int'(stage_sel) < STAGES) begin
      w_stage_sel = stage_sel;
    end else begin
      w_stage_sel = SW'(STAGES - 1);
    end
  end

  // Lane mask expanded to bit granularity.
  always_comb begin
    w_wmask = '0;
    for (int l = 0; l < LANES; l++) begin
      w_wmask[l*DW +: DW] = {DW{wr_lane_mask[l]}};
    end
  end

  assign w_wr_ok = wr_en && (int'(wr_stage) < STAGES) &&
                   (int'(wr_group) < GROUPS) && (int'(wr_entry) < ENTRIES);
  assign w_cw_ok = const_we && (int'(wr_stage) < STAGES);

  assign w_wr_merged = (r_tbl[wr_stage][wr_group][wr_entry] & ~w_wmask) |
                       (wr_data & w_wmask);

  // Write-first: a same-cycle write to the word being read is merged in.
  assign w_rd_raw  = r_tbl[r_stage][w_grp][w_ent];
  assign w_fwd_hit = w_wr_ok && (wr_stage == r_stage) &&
                     (wr_group == w_grp) && (wr_entry == w_ent);
  assign w_rd_word = w_fwd_hit ? ((w_rd_raw & ~w_wmask) | (wr_data & w_wmask))
                               : w_rd_raw;

  // Table storage with per-lane masked writes.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        for (int g = 0; g < GROUPS; g++) begin
          for (int e = 0; e < ENTRIES; e++) begin
            r_tbl[s][g][e] <= ID;
          end
        end
      end
    end else if (w_wr_ok) begin
      r_tbl[wr_stage][wr_group][wr_entry] <= w_wr_merged;
    end
  end

  // Per-stage constant registers.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        r_const[s] <= ID;
      end
    end else if (w_cw_ok) begin
      r_const[wr_stage] <= wr_data;
    end
  end

  // FSM next-state and control decode.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_adv        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = RUN;
          w_accept     = 1'b1;
        end else begin
          w_next_state = IDLE;
        end
      end
      RUN: begin
        if (!CEN) begin
          w_adv = 1'b1;
          if (w_last) begin
            w_next_state = DONE;
          end else begin
            w_next_state = RUN;
          end
        end else begin
          w_next_state = RUN;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // State, run parameters and registered outputs.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_stage    <= '0;
      r_last_grp <= '0;
      Q          <= ID;
      Q_valid    <= 1'b0;
      Q_const    <= ID;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_state <= w_next_state;
      Q       <= w_adv ? w_rd_word : ID;
      Q_valid <= w_adv;
      busy    <= (w_next_state != IDLE);
      done    <= (w_next_state == DONE);
      if (w_accept) begin
        r_stage    <= w_stage_sel;
        r_last_grp <= w_ng_last;
        Q_const    <= (w_cw_ok && (wr_stage == w_stage_sel)) ? wr_data
                                                             : r_const[w_stage_sel];
      end else if ((r_state != IDLE) && w_cw_ok && (wr_stage == r_stage)) begin
        Q_const <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_tw_buf_seq.sv
// Scoreboard bench for tw_buf_seq: a run enumerates its word addresses into a
// queue; the monitor pops one per valid Q and compares against a memory model.
module tb_tw_buf_seq;

  localparam int WW = 128;
  localparam logic [WW-1:0] ID = {2{64'd1}};

  typedef struct packed {
    logic [1:0] s;
    logic [1:0] g;
    logic [1:0] e;
  } tag_t;

  logic          CLK = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    stage_sel;
  logic [2:0]    num_groups;
  logic          CEN;
  logic          wr_en;
  logic [1:0]    wr_stage;
  logic [1:0]    wr_group;
  logic [1:0]    wr_entry;
  logic [1:0]    wr_lane_mask;
  logic [WW-1:0] wr_data;
  logic          const_we;
  logic [WW-1:0] Q;
  logic          Q_valid;
  logic [WW-1:0] Q_const;
  logic          busy;
  logic          done;

  tw_buf_seq dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .start        (start),
    .stage_sel    (stage_sel),
    .num_groups   (num_groups),
    .CEN          (CEN),
    .wr_en        (wr_en),
    .wr_stage     (wr_stage),
    .wr_group     (wr_group),
    .wr_entry     (wr_entry),
    .wr_lane_mask (wr_lane_mask),
    .wr_data      (wr_data),
    .const_we     (const_we),
    .Q            (Q),
    .Q_valid      (Q_valid),
    .Q_const      (Q_const),
    .busy         (busy),
    .done         (done)
  );

  always #5 CLK = ~CLK;

  int nvec = 0;
  int nerr = 0;

  // Reference model state
  logic [WW-1:0] m_tbl [3][4][4];
  logic [WW-1:0] m_const [3];
  tag_t          sb [$];
  int            m_left;
  bit            m_done;
  logic [1:0]    m_stage;
  logic [WW-1:0] exp_qconst;
  bit            exp_valid;
  bit            exp_busy;
  int            m_completed;
  int            done_cnt;
  bit            was_busy;
  bit            accepted;
  int            ng;

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: storage updates at the edge, run bookkeeping by word count.
  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 3; s++) begin
        m_const[s] = ID;
        for (int g = 0; g < 4; g++)
          for (int e = 0; e < 4; e++) m_tbl[s][g][e] = ID;
      end
      sb.delete();
      m_left = 0; m_done = 0; m_stage = 0;
      exp_qconst = ID; exp_valid = 0; exp_busy = 0;
    end else begin
      was_busy = (m_left > 0) || m_done;
      accepted = 0;
      if (wr_en && wr_stage < 3) begin
        for (int l = 0; l < 2; l++)
          if (wr_lane_mask[l]) m_tbl[wr_stage][wr_group][wr_entry][l*64 +: 64] = wr_data[l*64 +: 64];
      end
      if (const_we && wr_stage < 3) m_const[wr_stage] = wr_data;
      exp_valid = (m_left > 0) && !CEN;
      if (m_left > 0) begin
        if (!CEN) begin
          m_left--;
          if (m_left == 0) begin m_done = 1; m_completed++; end
        end
      end else if (m_done) begin
        m_done = 0;
      end else if (start) begin
        accepted = 1;
        m_stage = stage_sel;
        ng = (num_groups == 0 || num_groups > 4) ? 4 : int'(num_groups);
        m_left = ng * 16 * 4;
        for (int g = 0; g < ng; g++)
          for (int r = 0; r < 16; r++)
            for (int e = 0; e < 4; e++) sb.push_back('{s: m_stage, g: 2'(g), e: 2'(e)});
      end
      if (was_busy || accepted) exp_qconst = m_const[m_stage];
      exp_busy = (m_left > 0) || m_done;
    end
  end

  // Monitor: compares every cycle away from the active edge.
  always @(negedge CLK) begin
    tag_t t;
    chk("Q_valid", WW'(Q_valid), WW'(exp_valid));
    chk("busy", WW'(busy), WW'(exp_busy));
    chk("done", WW'(done), WW'(m_done));
    chk("Q_const", Q_const, exp_qconst);
    if (Q_valid) begin
      if (sb.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL sb_underflow: got valid Q %h with no expected word", Q);
      end else begin
        t = sb.pop_front();
        chk("Q_word", Q, m_tbl[t.s][t.g][t.e]);
      end
    end else begin
      chk("Q_idle", Q, ID);
    end
    if (done) begin
      done_cnt++;
      chk("words_left_at_done", WW'(sb.size()), WW'(0));
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; CEN = 0; wr_en = 0; const_we = 0;
    wr_lane_mask = 2'b00; wr_data = '0;
    wr_stage = 0; wr_group = 0; wr_entry = 0;
  endtask

  task automatic do_start(input logic [1:0] s, input logic [2:0] n);
    start = 1; stage_sel = s; num_groups = n;
    cyc();
    start = 0;
  endtask

  task automatic rand_traffic();
    CEN          = ($urandom_range(0, 3) == 0);
    wr_en        = ($urandom_range(0, 5) == 0);
    wr_stage     = 2'($urandom_range(0, 3));
    wr_group     = 2'($urandom_range(0, 3));
    wr_entry     = 2'($urandom_range(0, 3));
    wr_lane_mask = 2'($urandom_range(0, 3));
    wr_data      = {$urandom(), $urandom(), $urandom(), $urandom()};
    const_we     = ($urandom_range(0, 15) == 0);
    start        = ($urandom_range(0, 15) == 0);
    stage_sel    = 2'($urandom_range(0, 2));
    num_groups   = 3'($urandom_range(0, 7));
  endtask

  // Runs until the model reports idle; an expired budget counts as a failure.
  task automatic wait_idle(input int budget, input bit rnd);
    int n;
    n = 0;
    while ((m_left > 0 || m_done) && n < budget) begin
      if (rnd) rand_traffic();
      cyc();
      n++;
    end
    clear_inputs();
    nvec++;
    if (m_left > 0 || m_done) begin
      nerr++;
      $display("FAIL run_timeout: still busy after %0d cycles, required idle", n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] v;
    int idx;
    tag_t t;
    m_completed = 0; done_cnt = 0;
    rst_n = 0; stage_sel = 0; num_groups = 0;
    clear_inputs();
    repeat (3) cyc();
    rst_n = 1;
    repeat (2) cyc();

    // 1: identity run, one group
    do_start(2'd0, 3'd1);
    wait_idle(200, 0);
    cyc();

    // 2/3: load stage 1 with {g,e}, full run with a 3-cycle stall mid-group
    for (int g = 0; g < 4; g++)
      for (int e = 0; e < 4; e++) begin
        v = 64'(g * 16 + e);
        wr_en = 1; wr_stage = 2'd1; wr_group = 2'(g); wr_entry = 2'(e);
        wr_lane_mask = 2'b11; wr_data = {v, v};
        cyc();
      end
    clear_inputs();
    do_start(2'd1, 3'd4);
    repeat (42) cyc();
    CEN = 1;
    repeat (3) cyc();
    CEN = 0;
    wait_idle(400, 0);
    cyc();

    // 4: masked write to the word being read this cycle
    do_start(2'd1, 3'd2);
    repeat (21) cyc();
    idx = exp_valid ? 1 : 0;
    t = sb[idx];
    wr_en = 1; wr_stage = t.s; wr_group = t.g; wr_entry = t.e;
    wr_lane_mask = 2'b01; wr_data = {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};
    cyc();
    wr_en = 0;
    wait_idle(400, 0);
    cyc();

    // 5: const write then run stage 2; start while busy is ignored
    const_we = 1; wr_stage = 2'd2; wr_data = 128'h1000_7fffffff_00000001;
    cyc();
    const_we = 0;
    do_start(2'd2, 3'd1);
    repeat (5) cyc();
    do_start(2'd0, 3'd4);
    wait_idle(200, 0);
    cyc();

    // Randomised runs with background writes, stalls and stray starts
    for (int k = 0; k < 8; k++) begin
      do_start(2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)));
      wait_idle(2000, 1);
      cyc();
    end

    // 6: reset mid-run
    do_start(2'd1, 3'd4);
    repeat (30) cyc();
    rst_n = 0;
    #1;
    chk("rst_Q", Q, ID);
    chk("rst_Q_valid", WW'(Q_valid), WW'(0));
    chk("rst_busy", WW'(busy), WW'(0));
    chk("rst_done", WW'(done), WW'(0));
    chk("rst_Q_const", Q_const, ID);
    repeat (2) cyc();
    rst_n = 1;
    cyc();
    do_start(2'd1, 3'd1);
    wait_idle(200, 0);
    cyc();

    chk("done_pulses", WW'(done_cnt), WW'(m_completed));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
